// File: rtl/spi_pll_cfg_master.sv
// SPI initiator for the PLL configuration port (mode 0, 24-bit frames).
// Each host request becomes one {cmd, addr, data} frame sent MSB first.
// Optional build macro SPI_PLL_CFG_VERIFY_EN: after every write frame an
// automatic read-back frame is issued to the same address, and
// rsp_mismatch_o flags a read-back value that differs from the written data.
module spi_pll_cfg_master #(
  parameter int          CLK_DIV   = 2,
  parameter logic [7:0]  CMD_WRITE = 8'h80,
  parameter logic [7:0]  CMD_READ  = 8'h40
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       busy_o,
  output logic       spi_sck_o,
  output logic       spi_cs_n_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i
`ifdef SPI_PLL_CFG_VERIFY_EN
  ,
  output logic       rsp_mismatch_o
`endif
);

  // Host handshake: a request is taken on a clk_i edge where
  // req_valid_i && req_ready_o; the fields are captured on that edge and
  // req_ready_o stays low until the frame (and its gap) has completed.
  // Requests presented while busy are dropped, not queued.

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] H_FULL = CW'(CLK_DIV);
  localparam logic [CW-1:0] H_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    bit_q;
  logic [23:0]   tx_q;
  logic [7:0]    rx_q;
  logic          sck_q;
  logic          cs_n_q;
  logic          mosi_q;
  logic          ready_q;
  logic          rsp_valid_q;
  logic [7:0]    rdata_q;
  logic          write_q;
`ifdef SPI_PLL_CFG_VERIFY_EN
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;
  logic          rb_q;
  logic          mism_q;
`endif

  // Frame sequencer: all SPI pins and host responses are registered here.
  // SETUP runs one extra count so CS falls the cycle after accept and then
  // stays low with SCK low for a full half-period before the first rise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      write_q     <= 1'b0;
`ifdef SPI_PLL_CFG_VERIFY_EN
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rb_q        <= 1'b0;
      mism_q      <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && ready_q) begin
            write_q <= req_write_i;
            tx_q    <= {req_write_i ? CMD_WRITE : CMD_READ, req_addr_i,
                        req_write_i ? req_wdata_i : 8'h00};
`ifdef SPI_PLL_CFG_VERIFY_EN
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
`endif
            ready_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          cs_n_q <= 1'b0;
          mosi_q <= tx_q[23];
          if (cnt_q == H_FULL) begin
            cnt_q   <= '0;
            sck_q   <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt_q == H_LAST) begin
            cnt_q <= '0;
            if (sck_q) begin
              // Falling edge: sample MISO and advance MOSI together.
              sck_q  <= 1'b0;
              rx_q   <= {rx_q[6:0], spi_miso_i};
              tx_q   <= {tx_q[22:0], 1'b0};
              mosi_q <= tx_q[22];
            end else if (bit_q == 5'd23) begin
              state_q <= S_HOLD;
            end else begin
              sck_q <= 1'b1;
              bit_q <= bit_q + 5'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == H_LAST) begin
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            state_q <= S_GAP;
`ifdef SPI_PLL_CFG_VERIFY_EN
            if (write_q && !rb_q) begin
              rb_q <= 1'b1;
            end else begin
              rsp_valid_q <= 1'b1;
              rdata_q     <= rx_q;
              mism_q      <= rb_q && (rx_q != wdata_q);
              rb_q        <= 1'b0;
            end
`else
            rsp_valid_q <= 1'b1;
            rdata_q     <= write_q ? 8'h00 : rx_q;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == H_LAST) begin
            cnt_q <= '0;
`ifdef SPI_PLL_CFG_VERIFY_EN
            if (rb_q) begin
              tx_q    <= {CMD_READ, addr_q, 8'h00};
              bit_q   <= '0;
              state_q <= S_SETUP;
            end else begin
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end
`else
            ready_q <= 1'b1;
            state_q <= S_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign spi_sck_o   = sck_q;
  assign spi_cs_n_o  = cs_n_q;
  assign spi_mosi_o  = mosi_q;
`ifdef SPI_PLL_CFG_VERIFY_EN
  assign rsp_mismatch_o = mism_q;
`endif

endmodule

// File: tb/tb_spi_pll_cfg_master.sv
// Bench for spi_pll_cfg_master: two instances (CLK_DIV=2 and CLK_DIV=1) share
// clock and reset; a slave model answers each frame with a chosen data byte
// and records the MOSI frames and SCK/CS timing seen on the wires.
module tb_spi_pll_cfg_master;

`ifdef SPI_PLL_CFG_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  // Clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] req_valid, req_write, req_ready, rsp_valid, busy;
  logic [1:0] sck, cs_n, mosi, miso;
  logic [7:0] req_addr [2];
  logic [7:0] req_wdata [2];
  logic [7:0] rsp_rdata [2];
`ifdef SPI_PLL_CFG_VERIFY_EN
  logic [1:0] mism;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_pll_cfg_master #(.CLK_DIV(g == 0 ? 2 : 1)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_write_i (req_write[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .busy_o      (busy[g]),
      .spi_sck_o   (sck[g]),
      .spi_cs_n_o  (cs_n[g]),
      .spi_mosi_o  (mosi[g]),
      .spi_miso_i  (miso[g])
`ifdef SPI_PLL_CFG_VERIFY_EN
      ,
      .rsp_mismatch_o (mism[g])
`endif
    );
  end

  // Slave model / wire monitor state
  logic [7:0]  slave_resp [2] = '{8'h00, 8'h00};
  logic [23:0] frames [2][16];
  int          frame_cnt [2] = '{0, 0};
  int          rsp_cnt [2]   = '{0, 0};
  int          viol [2]      = '{0, 0};
  int          gap_last [2]  = '{0, 0};
  int          gap_run [2]   = '{0, 0};
  int          bits [2], hi_len [2], lo_len [2], falls [2];
  logic        prev_sck [2], prev_cs [2], prev_mosi [2], had_fall [2];
  logic [23:0] cap [2];

  function automatic logic resp_bit(input logic [7:0] r, input int k);
    if (k >= 16 && k <= 23) return r[23 - k];
    return 1'b0;
  endfunction

  // Mode-0 slave: present the next MISO bit after each SCK fall, capture MOSI
  // on each SCK rise, and measure SCK phases and CS gaps in clk_i cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int hh;
      hh = (i == 0) ? 2 : 1;
      if (rst) begin
        bits[i] = 0; hi_len[i] = 0; lo_len[i] = 0; falls[i] = 0;
        had_fall[i] = 1'b0; prev_sck[i] = 1'b0; prev_cs[i] = 1'b1;
        prev_mosi[i] = 1'b0; miso[i] = 1'b0;
      end else begin
        if (rsp_valid[i]) rsp_cnt[i]++;
        if (cs_n[i] && sck[i]) viol[i]++;
        if (sck[i] && prev_sck[i] && (mosi[i] !== prev_mosi[i])) viol[i]++;
        if (!cs_n[i] && prev_cs[i]) begin
          bits[i] = 0; falls[i] = 0; had_fall[i] = 1'b0;
          gap_last[i] = gap_run[i];
          miso[i] = resp_bit(slave_resp[i], 0);
        end
        if (sck[i] && !prev_sck[i]) begin
          cap[i] = {cap[i][22:0], mosi[i]};
          bits[i]++;
          if (had_fall[i] && lo_len[i] != hh) viol[i]++;
          lo_len[i] = 0;
        end
        if (sck[i]) begin
          hi_len[i]++;
        end else if (prev_sck[i]) begin
          if (hi_len[i] != hh) viol[i]++;
          hi_len[i] = 0;
          had_fall[i] = 1'b1;
          falls[i]++;
          lo_len[i] = 1;
          miso[i] = resp_bit(slave_resp[i], falls[i]);
        end else if (!cs_n[i]) begin
          lo_len[i]++;
        end
        if (cs_n[i] && !prev_cs[i]) begin
          if (bits[i] == 24) begin
            frames[i][frame_cnt[i] % 16] = cap[i];
            frame_cnt[i]++;
          end else begin
            viol[i]++;
          end
          gap_run[i] = 0;
        end
        if (cs_n[i]) gap_run[i]++;
        prev_sck[i] = sck[i]; prev_cs[i] = cs_n[i]; prev_mosi[i] = mosi[i];
      end
    end
  end

  // Scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int inst, input string tag);
    int t;
    t = 0;
    while (req_ready[inst] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(t < 400), 32'd1);
  endtask

  // One request through the reference rules: frame contents, latency and
  // response values derive only from the request and the slave's byte.
  task automatic do_txn(input int inst, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] resp);
    int h, t, acc, lat, f0, rc0, v0, nfr, exp_lat;
    logic [7:0]  exp_rd;
    logic [23:0] exp_f;
    h       = (inst == 0) ? 2 : 1;
    nfr     = (VERIFY && wr) ? 2 : 1;
    exp_lat = (nfr == 2) ? 101 * h + 2 : 50 * h + 1;
    exp_rd  = !wr ? resp : (VERIFY ? resp : 8'h00);
    exp_f   = {wr ? 8'h80 : 8'h40, addr, wr ? wd : 8'h00};
    @(negedge clk);
    slave_resp[inst] = resp;
    f0 = frame_cnt[inst]; rc0 = rsp_cnt[inst]; v0 = viol[inst];
    req_valid[inst] = 1'b1; req_write[inst] = wr;
    req_addr[inst] = addr; req_wdata[inst] = wd;
    wait_ready(inst, "accept_wait");
    acc = cyc + 1;
    @(negedge clk);
    chk("ready_drop", 32'(req_ready[inst]), 32'd0);
    chk("busy_set", 32'(busy[inst]), 32'd1);
    req_valid[inst] = 1'b0;
    req_write[inst] = 1'($urandom_range(0, 1));
    req_addr[inst]  = 8'($urandom);
    req_wdata[inst] = 8'($urandom);
    t = 0;
    while (rsp_valid[inst] !== 1'b1 && t < 700) begin
      @(negedge clk);
      t++;
    end
    lat = cyc - acc;
    chk($sformatf("latency_i%0d", inst), 32'(lat), 32'(exp_lat));
    chk($sformatf("rdata_i%0d", inst), 32'(rsp_rdata[inst]), 32'(exp_rd));
`ifdef SPI_PLL_CFG_VERIFY_EN
    chk("mismatch_flag", 32'(mism[inst]), 32'(wr && (resp != wd)));
`endif
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid[inst]), 32'd0);
    chk("rdata_hold", 32'(rsp_rdata[inst]), 32'(exp_rd));
    chk("frame_count", 32'(frame_cnt[inst] - f0), 32'(nfr));
    chk("mosi_frame", 32'(frames[inst][f0 % 16]), 32'(exp_f));
    if (nfr == 2)
      chk("mosi_readback", 32'(frames[inst][(f0 + 1) % 16]), {8'h00, 8'h40, addr, 8'h00});
    chk("wire_timing", 32'(viol[inst] - v0), 32'd0);
    chk("rsp_count", 32'(rsp_cnt[inst] - rc0), 32'd1);
    wait_ready(inst, "gap_wait");
  endtask

  // Two reads with req_valid_i held high throughout; the second request is
  // presented while the first is busy and must only start after the gap.
  task automatic back_to_back(input int inst, input logic [7:0] resp);
    int h, acc1, acc2, f0, rc0, v0;
    logic [7:0] a1, a2;
    h  = (inst == 0) ? 2 : 1;
    a1 = 8'($urandom); a2 = 8'($urandom);
    @(negedge clk);
    slave_resp[inst] = resp;
    f0 = frame_cnt[inst]; rc0 = rsp_cnt[inst]; v0 = viol[inst];
    req_valid[inst] = 1'b1; req_write[inst] = 1'b0;
    req_addr[inst] = a1; req_wdata[inst] = 8'($urandom);
    wait_ready(inst, "b2b_first");
    acc1 = cyc + 1;
    @(negedge clk);
    req_addr[inst] = a2;
    wait_ready(inst, "b2b_second");
    acc2 = cyc + 1;
    @(negedge clk);
    req_valid[inst] = 1'b0;
    repeat (150) @(negedge clk);
    chk("b2b_spacing", 32'((acc2 - acc1) >= 51 * h + 2), 32'd1);
    chk("b2b_frames", 32'(frame_cnt[inst] - f0), 32'd2);
    chk("b2b_frame0", 32'(frames[inst][f0 % 16]), {8'h00, 8'h40, a1, 8'h00});
    chk("b2b_frame1", 32'(frames[inst][(f0 + 1) % 16]), {8'h00, 8'h40, a2, 8'h00});
    chk("b2b_rsp_count", 32'(rsp_cnt[inst] - rc0), 32'd2);
    chk("b2b_cs_gap", 32'(gap_last[inst] >= 1), 32'd1);
    chk("b2b_rdata", 32'(rsp_rdata[inst]), 32'(resp));
    chk("b2b_timing", 32'(viol[inst] - v0), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  // Directed sequence, then randomized requests, then mid-frame reset.
  initial begin
    int f0, rc0;
    req_valid = '0; req_write = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = 8'h00; req_wdata[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_cs_n%0d", i), 32'(cs_n[i]), 32'd1);
      chk($sformatf("rst_sck%0d", i), 32'(sck[i]), 32'd0);
      chk($sformatf("rst_mosi%0d", i), 32'(mosi[i]), 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_rsp_valid%0d", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("rst_rdata%0d", i), 32'(rsp_rdata[i]), 32'd0);
`ifdef SPI_PLL_CFG_VERIFY_EN
      chk($sformatf("rst_mismatch%0d", i), 32'(mism[i]), 32'd0);
`endif
    end
    rst = 1'b0;

    do_txn(0, 1'b1, 8'h11, 8'hA5, 8'hC3);
    do_txn(0, 1'b0, 8'h12, 8'h00, 8'h3C);
    do_txn(1, 1'b0, 8'h34, 8'h00, 8'h81);
    do_txn(0, 1'b1, 8'h20, 8'h5A, 8'h5B);
    do_txn(0, 1'b1, 8'h20, 8'h5A, 8'h5A);
    back_to_back(1, 8'hE7);

    for (int n = 0; n < 12; n++) begin
      int inst;
      logic wr;
      logic [7:0] a, wd, r;
      inst = $urandom_range(0, 1);
      wr   = 1'($urandom_range(0, 1));
      a    = 8'($urandom);
      wd   = 8'($urandom);
      r    = ($urandom_range(0, 3) == 0) ? wd : 8'($urandom);
      do_txn(inst, wr, a, wd, r);
    end

    // Reset in the middle of a read frame on the CLK_DIV=2 instance.
    @(negedge clk);
    slave_resp[0] = 8'($urandom);
    f0 = frame_cnt[0]; rc0 = rsp_cnt[0];
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h77;
    wait_ready(0, "rst_accept");
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("midframe_cs_low", 32'(cs_n[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", 32'(cs_n[0]), 32'd1);
    chk("abort_sck", 32'(sck[0]), 32'd0);
    chk("abort_mosi", 32'(mosi[0]), 32'd0);
    chk("abort_ready", 32'(req_ready[0]), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("abort_rdata", 32'(rsp_rdata[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt[0] - rc0), 32'd0);
    chk("abort_no_frame", 32'(frame_cnt[0] - f0), 32'd0);
    do_txn(0, 1'b0, 8'h42, 8'h00, 8'h96);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
